// File: rtl/gnrl_ram_arb_if.sv
// rtl/gnrl_ram_arb_if.sv - request/response and RAM pin bundle for gnrl_ram_arb
interface gnrl_ram_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = 4
);
    logic [1:0]    req_valid_i;
    logic [1:0]    req_ready_o;
    logic [1:0]    req_we_i;
    logic [MW-1:0] req_wem0_i;
    logic [MW-1:0] req_wem1_i;
    logic [AW-1:0] req_addr0_i;
    logic [AW-1:0] req_addr1_i;
    logic [DW-1:0] req_wdata0_i;
    logic [DW-1:0] req_wdata1_i;

    logic [1:0]    rsp_valid_o;
    logic [1:0]    rsp_ready_i;
    logic [DW-1:0] rsp_rdata0_o;
    logic [DW-1:0] rsp_rdata1_o;

    logic          ram_cs_o;
    logic          ram_we_o;
    logic [MW-1:0] ram_wem_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_din_o;
    logic [DW-1:0] ram_dout_i;

    modport slave (
        input  req_valid_i, req_we_i, req_wem0_i, req_wem1_i,
        input  req_addr0_i, req_addr1_i, req_wdata0_i, req_wdata1_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata0_o, rsp_rdata1_o,
        input  rsp_ready_i,
        output ram_cs_o, ram_we_o, ram_wem_o, ram_addr_o, ram_din_o,
        input  ram_dout_i
    );

    modport master (
        output req_valid_i, req_we_i, req_wem0_i, req_wem1_i,
        output req_addr0_i, req_addr1_i, req_wdata0_i, req_wdata1_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata0_o, rsp_rdata1_o,
        output rsp_ready_i,
        input  ram_cs_o, ram_we_o, ram_wem_o, ram_addr_o, ram_din_o,
        output ram_dout_i
    );
endinterface

// File: rtl/gnrl_ram_arb.sv
// rtl/gnrl_ram_arb.sv - two-port round-robin arbiter/sequencer for a one-cycle-latency SRAM
module gnrl_ram_arb #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = 4
) (
    input  logic           clk,
    input  logic           rst,
    gnrl_ram_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LIVE = 2'd1,
        S_HOLD = 2'd2
    } rsp_state_e;

    rsp_state_e    state_q [2];
    rsp_state_e    state_d [2];
    logic [1:0]    rd_q;
    logic [1:0]    rd_d;
    logic [DW-1:0] cap_q [2];
    logic [DW-1:0] cap_d [2];
    logic          last_q;
    logic          last_d;

    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_hs;
    logic [1:0]    elig;
    logic [1:0]    gnt;
    logic          gnt_idx;

    logic [MW-1:0] req_wem   [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic [DW-1:0] rsp_rdata [2];

    assign req_wem[0]   = bus.req_wem0_i;
    assign req_wem[1]   = bus.req_wem1_i;
    assign req_addr[0]  = bus.req_addr0_i;
    assign req_addr[1]  = bus.req_addr1_i;
    assign req_wdata[0] = bus.req_wdata0_i;
    assign req_wdata[1] = bus.req_wdata1_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= S_IDLE;
                cap_q[i]   <= '0;
            end
            rd_q   <= 2'b00;
            last_q <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cap_q[i]   <= cap_d[i];
            end
            rd_q   <= rd_d;
            last_q <= last_d;
        end
    end

    always_comb begin
        // a port may reissue in the same cycle its previous response drains
        for (int i = 0; i < 2; i++) begin
            rsp_valid[i] = (state_q[i] != S_IDLE);
            rsp_hs[i]    = rsp_valid[i] & bus.rsp_ready_i[i];
            elig[i]      = !rst & bus.req_valid_i[i] & ((state_q[i] == S_IDLE) | rsp_hs[i]);
        end

        if (elig == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end else begin
            gnt = elig;
        end
        gnt_idx = gnt[1];
        last_d  = (|gnt) ? gnt_idx : last_q;

        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            rd_d[i]    = rd_q[i];
            cap_d[i]   = cap_q[i];
            if (gnt[i]) begin
                state_d[i] = S_LIVE;
                rd_d[i]    = !bus.req_we_i[i];
            end else if (rsp_hs[i]) begin
                state_d[i] = S_IDLE;
            end else if (state_q[i] == S_LIVE) begin
                // RAM output is only valid for one cycle, so park it before it changes
                state_d[i] = S_HOLD;
                cap_d[i]   = rd_q[i] ? bus.ram_dout_i : '0;
            end
        end
    end

    always_comb begin
        bus.req_ready_o = gnt;
        bus.ram_cs_o    = |gnt;
        bus.ram_we_o    = 1'b0;
        bus.ram_wem_o   = '0;
        bus.ram_addr_o  = '0;
        bus.ram_din_o   = '0;
        if (|gnt) begin
            bus.ram_we_o   = bus.req_we_i[gnt_idx];
            bus.ram_wem_o  = bus.req_we_i[gnt_idx] ? req_wem[gnt_idx] : '0;
            bus.ram_addr_o = req_addr[gnt_idx];
            bus.ram_din_o  = req_wdata[gnt_idx];
        end

        bus.rsp_valid_o = rsp_valid;
        for (int i = 0; i < 2; i++) begin
            rsp_rdata[i] = '0;
            case (state_q[i])
                S_LIVE:  rsp_rdata[i] = rd_q[i] ? bus.ram_dout_i : '0;
                S_HOLD:  rsp_rdata[i] = cap_q[i];
                default: rsp_rdata[i] = '0;
            endcase
        end
        bus.rsp_rdata0_o = rsp_rdata[0];
        bus.rsp_rdata1_o = rsp_rdata[1];
    end

endmodule

// File: tb/tb_gnrl_ram_arb.sv
// tb/tb_gnrl_ram_arb.sv - scoreboard bench for gnrl_ram_arb with a behavioural SRAM
module tb_gnrl_ram_arb;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] mem [0:255];
    logic [31:0] act;

    gnrl_ram_arb_if #(.AW(32), .DW(32), .MW(4)) bus ();

    gnrl_ram_arb #(.AW(32), .DW(32), .MW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one-cycle-latency SRAM with byte enables; dout only changes on a read
    always @(posedge clk) begin
        if (bus.ram_cs_o) begin
            if (bus.ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_wem_o[b]) mem[bus.ram_addr_o[7:0]][8*b +: 8] <= bus.ram_din_o[8*b +: 8];
            end else begin
                bus.ram_dout_i <= mem[bus.ram_addr_o[7:0]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, a, e);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (bus.rsp_valid_o[i]) begin
                act = (i == 0) ? bus.rsp_rdata0_o : bus.rsp_rdata1_o;
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp%0d at %0t: got rdata %h expected no response", i, $time, act);
                end else if (i == 0) begin
                    chk("rsp_rdata0", act, q0[0]);
                    if (bus.rsp_ready_i[0]) void'(q0.pop_front());
                end else begin
                    chk("rsp_rdata1", act, q1[0]);
                    if (bus.rsp_ready_i[1]) void'(q1.pop_front());
                end
            end
        end
    end

    task automatic cycle(input logic [1:0] v, input logic [1:0] we,
                         input logic [3:0] wem0, input logic [3:0] wem1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] rr, input logic [1:0] egnt, input logic [1:0] erv,
                         input logic [31:0] e0, input logic [31:0] e1);
        logic        x_we;
        logic [3:0]  x_wem;
        logic [31:0] x_addr;
        logic [31:0] x_din;
        bus.req_valid_i  = v;
        bus.req_we_i     = we;
        bus.req_wem0_i   = wem0;
        bus.req_wem1_i   = wem1;
        bus.req_addr0_i  = a0;
        bus.req_addr1_i  = a1;
        bus.req_wdata0_i = d0;
        bus.req_wdata1_i = d1;
        bus.rsp_ready_i  = rr;
        x_we = 1'b0; x_wem = 4'h0; x_addr = 32'h0; x_din = 32'h0;
        if (egnt[0]) begin
            x_we = we[0]; x_wem = we[0] ? wem0 : 4'h0; x_addr = a0; x_din = d0;
        end else if (egnt[1]) begin
            x_we = we[1]; x_wem = we[1] ? wem1 : 4'h0; x_addr = a1; x_din = d1;
        end
        @(negedge clk);
        chk("req_ready", 32'(bus.req_ready_o), 32'(egnt));
        chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(erv));
        chk("ram_cs",    32'(bus.ram_cs_o),    32'(|egnt));
        chk("ram_we",    32'(bus.ram_we_o),    32'(x_we));
        chk("ram_wem",   32'(bus.ram_wem_o),   32'(x_wem));
        chk("ram_addr",  bus.ram_addr_o,       x_addr);
        chk("ram_din",   bus.ram_din_o,        x_din);
        if (egnt[0]) q0.push_back(e0);
        if (egnt[1]) q1.push_back(e1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[8'h10] <= 32'hDEADBEEF;
        mem[8'h11] <= 32'h12345678;
        mem[8'h20] <= 32'hA5A5A5A5;
        bus.ram_dout_i <= 32'h0;

        rst = 1'b1;
        bus.req_valid_i = 2'b11; bus.req_we_i = 2'b00;
        bus.req_wem0_i = 4'h0; bus.req_wem1_i = 4'h0;
        bus.req_addr0_i = 32'h10; bus.req_addr1_i = 32'h11;
        bus.req_wdata0_i = 32'h0; bus.req_wdata1_i = 32'h0;
        bus.rsp_ready_i = 2'b11;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready_o), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
        chk("rst_ram_cs",    32'(bus.ram_cs_o),    32'h0);
        chk("rst_rdata0",    bus.rsp_rdata0_o,     32'h0);
        chk("rst_rdata1",    bus.rsp_rdata1_o,     32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // contention from reset: 0,1,0,1
        cycle(2'b11, 2'b00, 4'h0, 4'h0, 32'h10, 32'h11, 0, 0, 2'b11, 2'b01, 2'b00, 32'hDEADBEEF, 0);
        cycle(2'b11, 2'b00, 4'h0, 4'h0, 32'h10, 32'h11, 0, 0, 2'b11, 2'b10, 2'b01, 0, 32'h12345678);
        cycle(2'b11, 2'b00, 4'h0, 4'h0, 32'h10, 32'h11, 0, 0, 2'b11, 2'b01, 2'b10, 32'hDEADBEEF, 0);
        cycle(2'b11, 2'b00, 4'h0, 4'h0, 32'h10, 32'h11, 0, 0, 2'b11, 2'b10, 2'b01, 0, 32'h12345678);
        cycle(2'b00, 2'b00, 4'h0, 4'h0, 32'h0,  32'h0,  0, 0, 2'b11, 2'b00, 2'b10, 0, 0);
        cycle(2'b00, 2'b00, 4'h0, 4'h0, 32'h0,  32'h0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);

        // single read on port 0
        cycle(2'b01, 2'b00, 4'h0, 4'h0, 32'h10, 32'h0, 0, 0, 2'b11, 2'b01, 2'b00, 32'hDEADBEEF, 0);
        cycle(2'b00, 2'b00, 4'h0, 4'h0, 32'h0,  32'h0, 0, 0, 2'b11, 2'b00, 2'b01, 0, 0);
        cycle(2'b00, 2'b00, 4'h0, 4'h0, 32'h0,  32'h0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0);

        // byte write then read on port 1
        cycle(2'b10, 2'b10, 4'h0, 4'b0101, 32'h0, 32'h4, 0, 32'h11223344, 2'b11, 2'b10, 2'b00, 0, 32'h0);
        cycle(2'b10, 2'b00, 4'h0, 4'h0,    32'h0, 32'h4, 0, 0,            2'b11, 2'b10, 2'b10, 0, 32'h00220044);
        cycle(2'b00, 2'b00, 4'h0, 4'h0,    32'h0, 32'h0, 0, 0,            2'b11, 2'b00, 2'b10, 0, 0);

        // backpressure on port 0 while port 1 overwrites the same word; then drain + reissue
        cycle(2'b01, 2'b00, 4'h0, 4'h0, 32'h20, 32'h0,  0, 0, 2'b10, 2'b01, 2'b00, 32'hA5A5A5A5, 0);
        cycle(2'b11, 2'b10, 4'h0, 4'hF, 32'h20, 32'h20, 0, 0, 2'b10, 2'b10, 2'b01, 0, 32'h0);
        cycle(2'b01, 2'b00, 4'h0, 4'h0, 32'h20, 32'h0,  0, 0, 2'b10, 2'b00, 2'b11, 0, 0);
        cycle(2'b01, 2'b00, 4'h0, 4'h0, 32'h20, 32'h0,  0, 0, 2'b10, 2'b00, 2'b01, 0, 0);
        cycle(2'b01, 2'b00, 4'h0, 4'h0, 32'h20, 32'h0,  0, 0, 2'b11, 2'b01, 2'b01, 32'h0, 0);
        cycle(2'b00, 2'b00, 4'h0, 4'h0, 32'h0,  32'h0,  0, 0, 2'b11, 2'b00, 2'b01, 0, 0);
        cycle(2'b00, 2'b00, 4'h0, 4'h0, 32'h0,  32'h0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);

        // port 1 hold, then drain without reissue
        cycle(2'b10, 2'b00, 4'h0, 4'h0, 32'h0, 32'h10, 0, 0, 2'b11, 2'b10, 2'b00, 0, 32'hDEADBEEF);
        cycle(2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0,  0, 0, 2'b01, 2'b00, 2'b10, 0, 0);
        cycle(2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0,  0, 0, 2'b11, 2'b00, 2'b10, 0, 0);
        cycle(2'b00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);

        // reset while port 1 is LIVE
        cycle(2'b10, 2'b00, 4'h0, 4'h0, 32'h0, 32'h11, 0, 0, 2'b11, 2'b10, 2'b00, 0, 32'h12345678);
        bus.req_valid_i = 2'b11;
        bus.req_addr0_i = 32'h10;
        bus.req_addr1_i = 32'h11;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
        chk("midrst_ram_cs",    32'(bus.ram_cs_o),    32'h0);
        chk("midrst_req_ready", 32'(bus.req_ready_o), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(2'b11, 2'b00, 4'h0, 4'h0, 32'h10, 32'h11, 0, 0, 2'b11, 2'b01, 2'b00, 32'hDEADBEEF, 0);
        cycle(2'b00, 2'b00, 4'h0, 4'h0, 32'h0,  32'h0,  0, 0, 2'b11, 2'b00, 2'b01, 0, 0);
        cycle(2'b00, 2'b00, 4'h0, 4'h0, 32'h0,  32'h0,  0, 0, 2'b11, 2'b00, 2'b00, 0, 0);

        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
